reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, number of sequenced reset outputs; legal range 1..8.
REQ-002 SHALL have parameter HOLD_CYC, default 4, cycles all outputs stay asserted after reset release; legal range >= 1.
REQ-003 SHALL have parameter STAGE_DLY, default 8, cycles between successive stage releases; legal range >= 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port async_rst_ni, input, 1 bit: reset, asynchronous and active-low; driven from the reset-deassert synchronizer, so deassertion is already clk-synchronous.
REQ-006 SHALL have port sw_rst_req_i, input, 1 bit: synchronous software reset request, sampled every rising edge.
REQ-007 SHALL have port rst_no, output, NUM_STAGES bits: active-low resets to downstream blocks; bit 0 is released first.
REQ-008 SHALL have port busy_o, output, 1 bit: high while the sequence is not complete.
REQ-009 SHALL have port seq_done_o, output, 1 bit: high once all stages are released.
REQ-010 SHALL have port stage_o, output, 4 bits: index of the next stage to release; equals NUM_STAGES when done.

Function
REQ-011 SHALL implement states HOLD, RELEASE and DONE; all outputs SHALL be registered.
REQ-012 HOLD: all rst_no bits 0 and the counter increments each edge; on the edge where the counter equals HOLD_CYC-1, SHALL set rst_no[0]=1, clear the counter, set stage_o=1, and go to RELEASE (DONE if NUM_STAGES=1).
REQ-013 RELEASE: the counter increments each edge; on the edge where the counter equals STAGE_DLY-1, SHALL set rst_no[stage_o]=1, increment stage_o and clear the counter.
REQ-014 When stage_o reaches NUM_STAGES, SHALL go to DONE on that same edge.
REQ-015 Counting edges after reset deassertion from 1, rst_no[k] SHALL rise after edge HOLD_CYC + k*STAGE_DLY.
REQ-016 DONE: seq_done_o=1 and busy_o=0 from the edge after the last release.
REQ-017 Released bits SHALL never return to 0 except via async reset or sw_rst_req_i, and SHALL be monotonic in index (rst_no[k]=1 implies rst_no[j]=1 for all j<k).
REQ-018 sw_rst_req_i=1 in RELEASE or DONE SHALL, on that edge, clear all rst_no bits, seq_done_o and stage_o, set busy_o=1, clear the counter, and enter HOLD.
REQ-019 sw_rst_req_i=1 in HOLD SHALL clear the counter, restarting the full HOLD_CYC interval.
REQ-020 A request held high for multiple cycles SHALL keep the block in HOLD with the counter at 0 until it drops.
REQ-021 Counter width SHALL be sized for max(HOLD_CYC, STAGE_DLY)-1 and SHALL never wrap within a state.

Reset
REQ-022 async_rst_ni=0 SHALL, immediately and without a clock, force: state HOLD, counter 0, rst_no all 0, busy_o=1, seq_done_o=0, stage_o=0.
REQ-023 Reset asserted mid-sequence, in any state, SHALL abort the sequence and apply REQ-022; the sequence SHALL restart from HOLD after deassertion.

Verification (defaults: NUM_STAGES=3, HOLD_CYC=4, STAGE_DLY=8)
REQ-024 Release async_rst_ni, sw_rst_req_i=0 -> rst_no 000->001 after edge 4, 011 after edge 12, 111 after edge 20; seq_done_o=1 and busy_o=0 after edge 21; stage_o steps 0,1,2,3.
REQ-025 Pulse sw_rst_req_i for 1 cycle in DONE at edge N -> rst_no=000 and busy_o=1 after edge N; rst_no[0] rises after edge N+4.
REQ-026 Pulse sw_rst_req_i at edge 2, with reset released and the block in HOLD -> rst_no[0] rises after edge 6, not edge 4.
REQ-027 Assert async_rst_ni=0 between clock edges while rst_no=011 -> rst_no=000, stage_o=0 and seq_done_o=0 with no clock edge; re-release -> full REQ-024 timing.
REQ-028 Hold sw_rst_req_i=1 for 10 cycles starting in RELEASE -> rst_no stays 000 throughout; rst_no[0] rises 4 edges after the last edge that samples the request high.
REQ-029 Assertions checked for all scenarios and parameter sets NUM_STAGES=1 and 8, HOLD_CYC=1, STAGE_DLY=1 -> REQ-017 monotonicity holds and busy_o == !seq_done_o every cycle.

Source files
------------

// File: rtl/reset_sequencer.sv
`default_nettype none
// reset_sequencer: holds all downstream resets after release, then frees them
// one stage at a time (bit 0 first) with fixed spacing; rev 1.0
module reset_sequencer #(
   parameter int NUM_STAGES = 3,
   parameter int HOLD_CYC   = 4,
   parameter int STAGE_DLY  = 8
) (
   input  logic                  clk,
   input  logic                  async_rst_ni,
   input  logic                  sw_rst_req_i,
   output logic [NUM_STAGES-1:0] rst_no,
   output logic                  busy_o,
   output logic                  seq_done_o,
   output logic [3:0]            stage_o
);

   localparam int MAX_CYC = (HOLD_CYC > STAGE_DLY) ? HOLD_CYC : STAGE_DLY;
   localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
   localparam logic [3:0]       LAST_STAGE = 4'(NUM_STAGES);

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Thermometer code with the lowest n bits set keeps releases monotonic.
   function automatic logic [NUM_STAGES-1:0] therm(input logic [3:0] n);
      logic [NUM_STAGES-1:0] t;
      for (int k = 0; k < NUM_STAGES; k++) begin
         t[k] = (4'(k) < n);
      end
      return t;
   endfunction

   always_ff @(posedge clk or negedge async_rst_ni) begin
      if (!async_rst_ni) begin
         state      <= HOLD;
         cnt        <= '0;
         rst_no     <= '0;
         busy_o     <= 1'b1;
         seq_done_o <= 1'b0;
         stage_o    <= 4'd0;
      end else if (sw_rst_req_i) begin
         state      <= HOLD;
         cnt        <= '0;
         rst_no     <= '0;
         busy_o     <= 1'b1;
         seq_done_o <= 1'b0;
         stage_o    <= 4'd0;
      end else begin
         case (state)
            HOLD: begin
               if (cnt == HOLD_LAST) begin
                  rst_no  <= therm(4'd1);
                  cnt     <= '0;
                  stage_o <= 4'd1;
                  state   <= (NUM_STAGES == 1) ? DONE : RELEASE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RELEASE: begin
               if (cnt == STAGE_LAST) begin
                  rst_no  <= therm(stage_o + 4'd1);
                  stage_o <= stage_o + 4'd1;
                  cnt     <= '0;
                  if (stage_o + 4'd1 == LAST_STAGE) begin
                     state <= DONE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               busy_o     <= 1'b0;
               seq_done_o <= 1'b1;
            end
            default: state <= HOLD;
         endcase
      end
   end

endmodule
`default_nettype wire
